// File: rtl/data_mem_sized.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_sized
// Purpose  : Byte-addressed 32-bit data memory with sized, sign/zero-extended
//            loads, registered read path and a word-per-cycle clear sequencer.
// Revision : 1.0
// ============================================================================
module data_mem_sized #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  input  logic                  WriteEnable,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  LoadUnsigned,
  input  logic                  Clear,
  output logic [31:0]           ReadData,
  output logic                  ReadValid,
  output logic                  Busy,
  output logic                  Misaligned,
  output logic                  OutOfRange
);

  localparam int         c_IW       = $clog2(DEPTH);
  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_CLEAR = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [c_IW-1:0] r_count;
  logic [31:0]     r_mem [DEPTH];

  logic [c_IW-1:0] w_idx;
  logic [1:0]      w_lane;
  logic            w_oor;
  logic            w_mis;
  logic            w_req;
  logic            w_legal;
  logic            w_store;
  logic            w_load;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ldata;

  assign w_idx  = Address[c_IW+1:2];
  assign w_lane = Address[1:0];

  // Any set bit above the word-index field puts the address past the array.
  generate
    if (ADDR_WIDTH > c_IW + 2) begin : g_range_check
      assign w_oor = |Address[ADDR_WIDTH-1:c_IW+2];
    end else begin : g_range_full
      assign w_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    w_mis = 1'b0;
    case (Size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = Address[0];
      default: w_mis = |Address[1:0];
    endcase
  end

  assign w_req   = (WriteEnable | MemRead) & (r_state == c_ST_IDLE);
  assign w_legal = w_req & ~w_oor & ~w_mis;
  assign w_store = w_legal & WriteEnable & Reset;
  assign w_load  = w_legal & MemRead & ~WriteEnable;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    case (Size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = Address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

  // Array has no reset; it is only ever cleared by the sequencer.
  always_ff @(posedge Clock) begin
    if (Reset && (r_state == c_ST_CLEAR)) begin
      r_mem[r_count] <= '0;
    end else if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = Address[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ldata = w_word;
    case (Size)
      2'b00:   w_ldata = LoadUnsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ldata = LoadUnsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ldata = w_word;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ReadData   <= '0;
      ReadValid  <= 1'b0;
      Misaligned <= 1'b0;
      OutOfRange <= 1'b0;
    end else begin
      ReadValid  <= w_load;
      if (w_load) begin
        ReadData <= w_ldata;
      end
      OutOfRange <= w_req & w_oor;
      Misaligned <= w_req & ~w_oor & w_mis;
    end
  end

  // Sequencer: state register, next-state logic, output decode.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= (r_state == c_ST_CLEAR) ? r_count + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (Clear) w_state_nxt = c_ST_CLEAR;
      c_ST_CLEAR: if (&r_count) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (r_state == c_ST_CLEAR);
  end

endmodule
`default_nettype wire
